// File: rtl/v2f_alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : v2f_alu_pkg
// Brief    : Shared types, constants and the combinational ALU evaluation
//            function for the v2f arithmetic arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package v2f_alu_pkg;

  localparam int V2F_WORD_W = 32;
  localparam logic signed [V2F_WORD_W-1:0] V2F_INT_MIN = 32'sh8000_0000;

  typedef enum logic [3:0] {
    V2F_OP_ADD = 4'd0,
    V2F_OP_SUB = 4'd1,
    V2F_OP_MUL = 4'd2,
    V2F_OP_DIV = 4'd3,
    V2F_OP_MOD = 4'd4,
    V2F_OP_AND = 4'd5,
    V2F_OP_OR  = 4'd6,
    V2F_OP_XOR = 4'd7,
    V2F_OP_SHL = 4'd8,
    V2F_OP_SHR = 4'd9
  } v2f_alu_op_t;

  // Per-requester lifecycle of one outstanding operation
  typedef enum logic [1:0] {
    V2F_ST_IDLE     = 2'd0,
    V2F_ST_INFLIGHT = 2'd1,
    V2F_ST_HELD     = 2'd2
  } v2f_req_state_t;

  typedef struct packed {
    logic [V2F_WORD_W-1:0] y;
    logic                  err;
  } v2f_alu_res_t;

  // Signed two's-complement evaluation; division corner cases are pinned so
  // the result never depends on simulator or synthesis-tool behaviour.
  function automatic v2f_alu_res_t v2f_alu_eval(
    input logic [3:0]                   op,
    input logic signed [V2F_WORD_W-1:0] a,
    input logic signed [V2F_WORD_W-1:0] b
  );
    v2f_alu_res_t res;
    res.y   = '0;
    res.err = 1'b0;
    case (op)
      V2F_OP_ADD: res.y = a + b;
      V2F_OP_SUB: res.y = a - b;
      V2F_OP_MUL: res.y = a * b;
      V2F_OP_DIV: begin
        if (b == '0)                          res.y = '0;
        else if (a == V2F_INT_MIN && b == '1) res.y = V2F_INT_MIN;
        else                                  res.y = a / b;
      end
      V2F_OP_MOD: begin
        if (b == '0)                          res.y = '0;
        else if (a == V2F_INT_MIN && b == '1) res.y = '0;
        else                                  res.y = a % b;
      end
      V2F_OP_AND: res.y = a & b;
      V2F_OP_OR:  res.y = a | b;
      V2F_OP_XOR: res.y = a ^ b;
      V2F_OP_SHL: res.y = a <<  b[4:0];
      V2F_OP_SHR: res.y = a >>> b[4:0];
      default:    res.err = 1'b1;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/v2f_alu_core.sv
//------------------------------------------------------------------------------
// Module   : v2f_alu_core
// Brief    : Shared arithmetic datapath. Evaluates on entry, then carries
//            result, valid bit and requester tag through LATENCY registers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module v2f_alu_core
  import v2f_alu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [3:0]            in_op,
  input  logic [V2F_WORD_W-1:0] in_a,
  input  logic [V2F_WORD_W-1:0] in_b,
  output logic                  out_valid,
  output logic [TAG_W-1:0]      out_tag,
  output logic [V2F_WORD_W-1:0] out_y,
  output logic                  out_err
);

  v2f_alu_res_t           w_res;
  logic [LATENCY-1:0]     r_valid;
  logic [TAG_W-1:0]       r_tag [LATENCY];
  v2f_alu_res_t           r_res [LATENCY];

  assign w_res = v2f_alu_eval(in_op, in_a, in_b);

  // Shift register of result, tag and valid; reset flushes every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_tag[s] <= '0;
        r_res[s] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_tag[0]   <= in_tag;
      r_res[0]   <= w_res;
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_tag[s]   <= r_tag[s-1];
        r_res[s]   <= r_res[s-1];
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign out_tag   = r_tag[LATENCY-1];
  assign out_y     = r_res[LATENCY-1].y;
  assign out_err   = r_res[LATENCY-1].err;

endmodule

`default_nettype wire

// File: rtl/v2f_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : v2f_alu_arbiter
// Brief    : Shares one pipelined ALU among N_REQ requesters. One grant per
//            cycle, one outstanding op per requester, per-port result hold.
//            Define V2F_ARB_ROUND_ROBIN_EN for rotating priority; otherwise
//            the lowest eligible index wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module v2f_alu_arbiter
  import v2f_alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [4*N_REQ-1:0]          req_op,
  input  logic [V2F_WORD_W*N_REQ-1:0] req_a,
  input  logic [V2F_WORD_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [V2F_WORD_W*N_REQ-1:0] rsp_y,
  output logic [N_REQ-1:0]            rsp_err,
  output logic                        busy
);

  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      w_elig;
  logic [N_REQ-1:0]      w_grant;
  logic [N_REQ-1:0]      w_outstanding;
  logic [N_REQ-1:0]      w_wb;
  logic [TAG_W-1:0]      w_gidx;
  logic                  w_accept;
  logic                  w_out_valid;
  logic [TAG_W-1:0]      w_out_tag;
  logic [V2F_WORD_W-1:0] w_out_y;
  logic                  w_out_err;

  // Reset gating keeps req_ready low while rst_n is asserted
  assign w_elig   = req_valid & ~w_outstanding & {N_REQ{rst_n}};
  assign w_accept = |w_elig;
  assign w_grant  = {{(N_REQ-1){1'b0}}, w_accept} << w_gidx;
  assign req_ready = w_grant;
  assign busy      = |w_outstanding;

`ifdef V2F_ARB_ROUND_ROBIN_EN
  logic [TAG_W-1:0] r_ptr;
  int               w_dist;
  int               w_best;

  // Pick the eligible requester closest to the pointer, walking upward
  always_comb begin
    w_gidx = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i >= int'(r_ptr)) w_dist = i - int'(r_ptr);
      else                  w_dist = i + N_REQ - int'(r_ptr);
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_gidx = TAG_W'(i);
      end
    end
  end

  // Pointer moves just past the requester that was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_accept) r_ptr <= (w_gidx == TAG_W'(N_REQ-1)) ? '0 : w_gidx + 1'b1;
  end
`else
  // Fixed priority: lowest eligible index wins
  always_comb begin
    w_gidx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_elig[i]) w_gidx = TAG_W'(i);
    end
  end
`endif

  v2f_alu_core #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_accept),
    .in_tag    (w_gidx),
    .in_op     (req_op[w_gidx*4 +: 4]),
    .in_a      (req_a[w_gidx*V2F_WORD_W +: V2F_WORD_W]),
    .in_b      (req_b[w_gidx*V2F_WORD_W +: V2F_WORD_W]),
    .out_valid (w_out_valid),
    .out_tag   (w_out_tag),
    .out_y     (w_out_y),
    .out_err   (w_out_err)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    v2f_req_state_t        r_state;
    logic [V2F_WORD_W-1:0] r_y;
    logic                  r_err;

    assign w_outstanding[i] = (r_state != V2F_ST_IDLE);
    assign w_wb[i]          = w_out_valid & (w_out_tag == TAG_W'(i));
    // Pipeline exit is presented directly; the hold register takes over after
    assign rsp_valid[i]     = (r_state == V2F_ST_HELD) | w_wb[i];
    assign rsp_y[i*V2F_WORD_W +: V2F_WORD_W] = w_wb[i] ? w_out_y : r_y;
    assign rsp_err[i]       = w_wb[i] ? w_out_err : r_err;

    // IDLE -> INFLIGHT on accept, -> HELD on exit, -> IDLE on handshake
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= V2F_ST_IDLE;
        r_y     <= '0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          V2F_ST_IDLE: begin
            if (w_grant[i]) r_state <= V2F_ST_INFLIGHT;
          end
          V2F_ST_INFLIGHT: begin
            if (w_wb[i]) begin
              r_y     <= w_out_y;
              r_err   <= w_out_err;
              r_state <= rsp_ready[i] ? V2F_ST_IDLE : V2F_ST_HELD;
            end
          end
          V2F_ST_HELD: begin
            if (rsp_ready[i]) r_state <= V2F_ST_IDLE;
          end
          default: r_state <= V2F_ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_v2f_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_v2f_alu_arbiter
// Brief    : Directed self-checking bench. A LATENCY=1 instance covers single
//            ops, corner cases, arbitration, backpressure and reset; a
//            LATENCY=3 instance covers deep-pipeline routing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_v2f_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [15:0]  req_op;
  logic [127:0] req_a, req_b, rsp_y;
  logic         busy;

  logic [3:0]   d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [15:0]  d_req_op;
  logic [127:0] d_req_a, d_req_b, d_rsp_y;
  logic         d_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  v2f_alu_arbiter #(.N_REQ(4), .LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .busy(busy)
  );

  v2f_alu_arbiter #(.N_REQ(4), .LATENCY(3)) u_deep (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_op(d_req_op),
    .req_a(d_req_a), .req_b(d_req_b),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_y(d_rsp_y),
    .rsp_err(d_rsp_err), .busy(d_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One op on requester 0 with rsp_ready high; enters and leaves at posedge+1
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] y, input logic err);
    req_valid[0] = 1'b1;
    req_op[3:0]  = op;
    req_a[31:0]  = a;
    req_b[31:0]  = b;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 4'b0001);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk({tag, ".valid"}, rsp_valid, 4'b0001);
    chk({tag, ".y"}, rsp_y[31:0], y);
    chk({tag, ".err"}, rsp_err[0], err);
    next_cycle();
  endtask

  logic [31:0] deep_y [4];
  logic [3:0]  exp_gnt;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = 4'hF; req_op = '0; req_a = '0; req_b = '0;
    d_req_valid = '0; d_rsp_ready = 4'hF; d_req_op = '0; d_req_a = '0; d_req_b = '0;
    deep_y[0] = 32'hFFFF_FFFA;
    deep_y[1] = 32'hFFFF_FFF4;
    deep_y[2] = 32'hFFFF_FFEC;
    deep_y[3] = 32'h0001_0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", req_ready, 4'b0);
    chk("rst.rsp_valid", rsp_valid, 4'b0);
    chk("rst.rsp_y", rsp_y, 128'b0);
    chk("rst.rsp_err", rsp_err, 4'b0);
    chk("rst.busy", busy, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single op: ADD 7 + -10
    req_valid[0] = 1'b1; req_op[3:0] = 4'd0; req_a[31:0] = 32'd7; req_b[31:0] = 32'hFFFF_FFF6;
    @(negedge clk);
    chk("single.ready", req_ready, 4'b0001);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single.valid", rsp_valid, 4'b0001);
    chk("single.y", rsp_y[31:0], 32'hFFFF_FFFD);
    chk("single.err", rsp_err[0], 1'b0);
    chk("single.busy", busy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("single.drain_valid", rsp_valid, 4'b0);
    chk("single.drain_busy", busy, 1'b0);
    next_cycle();

    // Operation table including special results
    do_op("sub",    4'd1,  32'd5,         32'd8,         32'hFFFF_FFFD, 1'b0);
    do_op("mul",    4'd2,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0);
    do_op("div0",   4'd3,  32'd7,         32'd0,         32'h0,         1'b0);
    do_op("divneg", 4'd3,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("divmin", 4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("mod",    4'd4,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("modmin", 4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
    do_op("mod0",   4'd4,  32'd7,         32'd0,         32'h0,         1'b0);
    do_op("and",    4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    do_op("or",     4'd6,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0);
    do_op("xor",    4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    do_op("shl",    4'd8,  32'd1,         32'h21,        32'h2,         1'b0);
    do_op("shr",    4'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0);
    do_op("ill12",  4'd12, 32'd5,         32'd5,         32'h0,         1'b1);
    do_op("ill15",  4'd15, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b1);

    // Two requesters always valid: grants alternate 0,1 in either priority mode
    req_op = 16'h0000;
    req_a[31:0] = 32'd1; req_b[31:0] = 32'd1;
    req_a[63:32] = 32'd2; req_b[63:32] = 32'd2;
    req_valid = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("alt.gnt%0d", c), req_ready, (c % 2 == 0) ? 4'b0001 : 4'b0010);
      if (c > 0) chk($sformatf("alt.rsp%0d", c), rsp_valid, (c % 2 == 1) ? 4'b0001 : 4'b0010);
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();

    // Backpressure on requester 2
    rsp_ready[2] = 1'b0;
    req_op[11:8] = 4'd5; req_a[95:64] = 32'hF0F0_F0F0; req_b[95:64] = 32'h0FF0_0FF0;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("bp.accept", req_ready, 4'b0100);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp.valid%0d", k), rsp_valid, 4'b0100);
      chk($sformatf("bp.y%0d", k), rsp_y[95:64], 32'h00F0_00F0);
      chk($sformatf("bp.ready%0d", k), req_ready, 4'b0000);
      next_cycle();
    end
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    chk("bp.hs_ready", req_ready, 4'b0000);
    chk("bp.hs_valid", rsp_valid, 4'b0100);
    next_cycle();
    @(negedge clk);
    chk("bp.reaccept", req_ready, 4'b0100);
    next_cycle();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("bp.second_valid", rsp_valid, 4'b0100);
    chk("bp.second_y", rsp_y[95:64], 32'h00F0_00F0);
    next_cycle();
    next_cycle();

    // Reset with two operations outstanding
    rsp_ready = 4'b0000;
    req_op = 16'h0000;
    req_valid = 4'b0011;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rmid.pre_valid", rsp_valid, 4'b0011);
    chk("rmid.pre_busy", busy, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rmid.valid", rsp_valid, 4'b0);
    chk("rmid.y", rsp_y, 128'b0);
    chk("rmid.err", rsp_err, 4'b0);
    chk("rmid.busy", busy, 1'b0);
    chk("rmid.ready", req_ready, 4'b0);
    req_valid = '0;
    rsp_ready = 4'hF;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid.post_valid", rsp_valid, 4'b0);
    chk("rmid.post_busy", busy, 1'b0);
    next_cycle();

    // All four requesters valid, pointer fresh from reset
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
`ifdef V2F_ARB_ROUND_ROBIN_EN
      exp_gnt = 4'b0001 << (c % 4);
`else
      exp_gnt = 4'b0001 << (c % 2);
`endif
      @(negedge clk);
      chk($sformatf("all4.gnt%0d", c), req_ready, exp_gnt);
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();

    // Deep pipeline: MULs issued back to back on the LATENCY=3 instance
    d_req_op = 16'h2222;
    d_req_a[31:0]  = 32'd2;        d_req_b[31:0]  = 32'hFFFF_FFFD;
    d_req_a[63:32] = 32'd3;        d_req_b[63:32] = 32'hFFFF_FFFC;
    d_req_a[95:64] = 32'd4;        d_req_b[95:64] = 32'hFFFF_FFFB;
    d_req_a[127:96] = 32'h0001_0000; d_req_b[127:96] = 32'h0001_0001;
    for (int c = 0; c < 7; c++) begin
      d_req_valid = (c < 4) ? (4'hF << c) : 4'h0;
      @(negedge clk);
      chk($sformatf("deep.gnt%0d", c), d_req_ready, (c < 4) ? (4'b0001 << c) : 4'b0000);
      chk($sformatf("deep.rsp%0d", c), d_rsp_valid, (c >= 3) ? (4'b0001 << (c - 3)) : 4'b0000);
      if (c >= 3)
        chk($sformatf("deep.y%0d", c - 3), d_rsp_y[(c-3)*32 +: 32], deep_y[c-3]);
      next_cycle();
    end
    @(negedge clk);
    chk("deep.busy_end", d_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
